// File: rtl/fa_pipe.sv
// Pipelined WIDTH-bit add/subtract with carry-in; one SEG-bit carry segment is resolved per stage.
// Latency: NSTG cycles from input accept to OUT_VALID, plus one cycle per stall cycle.
// Backpressure: the whole pipe advances only when the output is empty or consumed; IN_READY = !OUT_VALID || OUT_READY.
//
// Ports:
//   CLK, RESET                 clock (rising edge) and asynchronous active-high reset
//   A, B, CI, SUB              operands, carry/borrow-in, subtract select (A-B-CI when SUB=1)
//   IN_VALID / IN_READY        input handshake
//   SUM, CO, OV                result, raw carry out of the MSB, signed overflow
//   OUT_VALID / OUT_READY      output handshake
module fa_pipe #(
    parameter int  WIDTH = 16,
    parameter int  SEG   = 8,
    localparam int NSTG  = WIDTH / SEG
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             CO,
    output logic             OV,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    // One SEG-bit slice of the carry chain; bit SEG is the carry out.
    function automatic logic [SEG:0] seg_add(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           c
    );
        return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Per-stage state. Stage k holds sum segments 0..k already resolved, the carry
    // out of segment k, and the (conditioned) operands for the segments still ahead.
    logic [NSTG-1:0]            v_q;
    logic [NSTG-1:0]            c_q;
    logic [NSTG-1:0][WIDTH-1:0] a_q;
    logic [NSTG-1:0][WIDTH-1:0] b_q;
    logic [NSTG-1:0][WIDTH-1:0] s_q;

    logic [NSTG-1:0]            v_d;
    logic [NSTG-1:0]            c_d;
    logic [NSTG-1:0][WIDTH-1:0] a_d;
    logic [NSTG-1:0][WIDTH-1:0] b_d;
    logic [NSTG-1:0][WIDTH-1:0] s_d;

    // Stalls are global: every stage moves together or none does, so bubbles are
    // never squeezed out and the output register holds steady while blocked.
    assign adv      = !OUT_VALID || OUT_READY;
    assign IN_READY = adv;

    // Subtract is A + ~B + ~CI, so CI acts as a borrow-in and CO=1 means no borrow.
    assign b_eff = SUB ? ~B : B;
    assign c_eff = SUB ? ~CI : CI;

    always_comb begin
        logic [SEG:0] seg;
        v_d = '0;
        c_d = '0;
        a_d = '0;
        b_d = '0;
        s_d = '0;
        seg = '0;

        // Stage 0 resolves segment 0 directly from the accepted operands.
        seg        = seg_add(A[SEG-1:0], b_eff[SEG-1:0], c_eff);
        v_d[0]     = IN_VALID;
        a_d[0]     = A;
        b_d[0]     = b_eff;
        s_d[0]     = '0;
        s_d[0][SEG-1:0] = seg[SEG-1:0];
        c_d[0]     = seg[SEG];

        // Later stages take the registered carry from the stage below and fill in
        // their own segment; higher operand segments ride along untouched.
        for (int k = 1; k < NSTG; k++) begin
            seg      = seg_add(a_q[k-1][k*SEG +: SEG], b_q[k-1][k*SEG +: SEG], c_q[k-1]);
            v_d[k]   = v_q[k-1];
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            s_d[k]   = s_q[k-1];
            s_d[k][k*SEG +: SEG] = seg[SEG-1:0];
            c_d[k]   = seg[SEG];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            v_q <= '0;
            c_q <= '0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
        end else if (adv) begin
            v_q <= v_d;
            c_q <= c_d;
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
        end
    end

    // The last stage is the output register. OV uses the operand MSBs captured at
    // accept (B already inverted for subtract), so it is correct for both modes and
    // reads 0 out of reset since all three bits are 0.
    assign OUT_VALID = v_q[NSTG-1];
    assign SUM       = s_q[NSTG-1];
    assign CO        = c_q[NSTG-1];
    assign OV        = (a_q[NSTG-1][WIDTH-1] == b_q[NSTG-1][WIDTH-1]) &&
                       (s_q[NSTG-1][WIDTH-1] != a_q[NSTG-1][WIDTH-1]);

    // Only the operand MSBs of the last stage feed OV; the rest have been consumed.
    logic unused_last_opnd;
    assign unused_last_opnd = ^{a_q[NSTG-1][WIDTH-2:0], b_q[NSTG-1][WIDTH-2:0]};

endmodule

// File: tb/tb_fa_pipe.sv
module tb_fa_pipe;

    logic        CLK = 1'b0;
    logic        RESET;

    logic [15:0] A, B, SUM;
    logic        CI, SUB, IN_VALID, IN_READY, CO, OV, OUT_VALID, OUT_READY;

    logic [23:0] a24, b24, sum24;
    logic        ci24, sub24, in_valid24, in_ready24, co24, ov24, out_valid24, out_ready24;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    fa_pipe #(.WIDTH(16), .SEG(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .A(A), .B(B), .CI(CI), .SUB(SUB),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .SUM(SUM), .CO(CO), .OV(OV),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    fa_pipe #(.WIDTH(24), .SEG(8)) dut24 (
        .CLK(CLK), .RESET(RESET),
        .A(a24), .B(b24), .CI(ci24), .SUB(sub24),
        .IN_VALID(in_valid24), .IN_READY(in_ready24),
        .SUM(sum24), .CO(co24), .OV(ov24),
        .OUT_VALID(out_valid24), .OUT_READY(out_ready24)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        in_valid24 = 1'b0;
        out_ready24 = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_vld got %b want 0", OUT_VALID); end
        n_checks++; if (SUM !== 16'h0000) begin n_fail++; $display("FAIL rst_sum got %h want 0000", SUM); end
        n_checks++; if (CO !== 1'b0) begin n_fail++; $display("FAIL rst_co got %b want 0", CO); end
        n_checks++; if (OV !== 1'b0) begin n_fail++; $display("FAIL rst_ov got %b want 0", OV); end
        n_checks++; if (out_valid24 !== 1'b0) begin n_fail++; $display("FAIL rst_vld24 got %b want 0", out_valid24); end
        n_checks++; if (sum24 !== 24'h000000) begin n_fail++; $display("FAIL rst_sum24 got %h want 000000", sum24); end
        #11 RESET = 1'b0;
        #1;
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", IN_READY); end
        n_checks++; if (in_ready24 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready24 got %b want 1", in_ready24); end
    endtask

    task automatic test_ripple();
        A = 16'h00FF; B = 16'h0001; CI = 1'b0; SUB = 1'b0;
        IN_VALID = 1'b1; OUT_READY = 1'b1;
        #1;
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL ripple_in_ready got %b want 1", IN_READY); end
        tick();
        IN_VALID = 1'b0;
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL ripple_early got %b want 0", OUT_VALID); end
        tick();
        n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL ripple_vld got %b want 1", OUT_VALID); end
        n_checks++; if (SUM !== 16'h0100) begin n_fail++; $display("FAIL ripple_sum got %h want 0100", SUM); end
        n_checks++; if (CO !== 1'b0) begin n_fail++; $display("FAIL ripple_co got %b want 0", CO); end
        n_checks++; if (OV !== 1'b0) begin n_fail++; $display("FAIL ripple_ov got %b want 0", OV); end
        idle(2);
    endtask

    task automatic test_overflow();
        vec_t v [3];
        v[0] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        v[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        v[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            A = v[i].a; B = v[i].b; CI = v[i].ci; SUB = v[i].sub;
            IN_VALID = 1'b1; OUT_READY = 1'b1;
            tick();
            IN_VALID = 1'b0;
            n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL ovf_early[%0d] got %b want 0", i, OUT_VALID); end
            tick();
            n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL ovf_vld[%0d] got %b want 1", i, OUT_VALID); end
            n_checks++; if (SUM !== v[i].s) begin n_fail++; $display("FAIL ovf_sum[%0d] got %h want %h", i, SUM, v[i].s); end
            n_checks++; if (CO !== v[i].co) begin n_fail++; $display("FAIL ovf_co[%0d] got %b want %b", i, CO, v[i].co); end
            n_checks++; if (OV !== v[i].ov) begin n_fail++; $display("FAIL ovf_ov[%0d] got %b want %b", i, OV, v[i].ov); end
            idle(2);
        end
    endtask

    task automatic test_subtract();
        vec_t v [4];
        v[0] = '{16'h0100, 16'h0001, 1'b1, 1'b1, 16'h00FE, 1'b1, 1'b0};
        v[1] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        v[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        v[3] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            A = v[i].a; B = v[i].b; CI = v[i].ci; SUB = v[i].sub;
            IN_VALID = 1'b1; OUT_READY = 1'b1;
            tick();
            IN_VALID = 1'b0;
            n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL sub_early[%0d] got %b want 0", i, OUT_VALID); end
            tick();
            n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL sub_vld[%0d] got %b want 1", i, OUT_VALID); end
            n_checks++; if (SUM !== v[i].s) begin n_fail++; $display("FAIL sub_sum[%0d] got %h want %h", i, SUM, v[i].s); end
            n_checks++; if (CO !== v[i].co) begin n_fail++; $display("FAIL sub_co[%0d] got %b want %b", i, CO, v[i].co); end
            n_checks++; if (OV !== v[i].ov) begin n_fail++; $display("FAIL sub_ov[%0d] got %b want %b", i, OV, v[i].ov); end
            idle(2);
        end
        SUB = 1'b0; CI = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_sum;
        B = 16'h1000; CI = 1'b0; SUB = 1'b0; OUT_READY = 1'b1;
        // Input i is accepted at edge i; its result is visible after edge i+1.
        for (int k = 0; k < 10; k++) begin
            IN_VALID = (k < 8);
            A = 16'(k);
            #1;
            n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b want 1", k, IN_READY); end
            tick();
            if (k >= 1 && k <= 8) begin
                exp_sum = 16'h1000 + 16'(k - 1);
                n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL b2b_vld[%0d] got %b want 1", k, OUT_VALID); end
                n_checks++; if (SUM !== exp_sum) begin n_fail++; $display("FAIL b2b_sum[%0d] got %h want %h", k, SUM, exp_sum); end
            end else begin
                n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_empty[%0d] got %b want 0", k, OUT_VALID); end
            end
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        int p = 0;
        int r = 0;
        int stall_left = 0;
        bit stall_started = 1'b0;
        bit acc, cons;
        logic [15:0] exp_sum;
        B = 16'h1000; CI = 1'b0; SUB = 1'b0;
        for (int cyc = 0; cyc < 40 && r < 8; cyc++) begin
            IN_VALID = (p < 8);
            A = 16'(p);
            if (OUT_VALID === 1'b1 && !stall_started) begin
                stall_started = 1'b1;
                stall_left = 3;
            end
            OUT_READY = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                n_checks++; if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", cyc, IN_READY); end
                n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_hold_vld[%0d] got %b want 1", cyc, OUT_VALID); end
                n_checks++; if (SUM !== 16'h1000) begin n_fail++; $display("FAIL bp_hold_sum[%0d] got %h want 1000", cyc, SUM); end
                stall_left--;
            end
            acc  = IN_VALID && (IN_READY === 1'b1);
            cons = (OUT_VALID === 1'b1) && OUT_READY;
            if (cons) begin
                exp_sum = 16'h1000 + 16'(r);
                n_checks++; if (SUM !== exp_sum) begin n_fail++; $display("FAIL bp_sum[%0d] got %h want %h", r, SUM, exp_sum); end
                r++;
            end
            if (acc) p++;
            tick();
        end
        n_checks++; if (r !== 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", r); end
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got %b want 0", OUT_VALID); end
        idle(2);
    endtask

    task automatic test_reset_midflight();
        B = 16'h1000; CI = 1'b0; SUB = 1'b0; OUT_READY = 1'b1;
        A = 16'h0001; IN_VALID = 1'b1;
        tick();
        A = 16'h0002;
        tick();
        IN_VALID = 1'b0;
        n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL mid_pre_vld got %b want 1", OUT_VALID); end
        #2 RESET = 1'b1;
        #1;
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vld got %b want 0", OUT_VALID); end
        n_checks++; if (SUM !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_sum got %h want 0000", SUM); end
        @(posedge CLK);
        #3 RESET = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d] got %b want 0", k, OUT_VALID); end
        end
        A = 16'h1234; B = 16'h0001; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_new_early got %b want 0", OUT_VALID); end
        tick();
        n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL mid_new_vld got %b want 1", OUT_VALID); end
        n_checks++; if (SUM !== 16'h1235) begin n_fail++; $display("FAIL mid_new_sum got %h want 1235", SUM); end
        idle(2);
    endtask

    task automatic test_reset_midflight_w24();
        b24 = 24'h100000; ci24 = 1'b0; sub24 = 1'b0; out_ready24 = 1'b1;
        a24 = 24'h000001; in_valid24 = 1'b1;
        tick();
        a24 = 24'h000002;
        tick();
        in_valid24 = 1'b0;
        n_checks++; if (out_valid24 !== 1'b0) begin n_fail++; $display("FAIL w24_early got %b want 0", out_valid24); end
        tick();
        n_checks++; if (out_valid24 !== 1'b1) begin n_fail++; $display("FAIL w24_pre_vld got %b want 1", out_valid24); end
        n_checks++; if (sum24 !== 24'h100001) begin n_fail++; $display("FAIL w24_pre_sum got %h want 100001", sum24); end
        #2 RESET = 1'b1;
        #1;
        n_checks++; if (out_valid24 !== 1'b0) begin n_fail++; $display("FAIL w24_rst_vld got %b want 0", out_valid24); end
        n_checks++; if (sum24 !== 24'h000000) begin n_fail++; $display("FAIL w24_rst_sum got %h want 000000", sum24); end
        @(posedge CLK);
        #3 RESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (out_valid24 !== 1'b0) begin n_fail++; $display("FAIL w24_stale[%0d] got %b want 0", k, out_valid24); end
        end
        a24 = 24'h00FFFF; b24 = 24'h000001; in_valid24 = 1'b1;
        tick();
        in_valid24 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (out_valid24 !== 1'b0) begin n_fail++; $display("FAIL w24_lat[%0d] got %b want 0", k, out_valid24); end
            tick();
        end
        n_checks++; if (out_valid24 !== 1'b1) begin n_fail++; $display("FAIL w24_vld got %b want 1", out_valid24); end
        n_checks++; if (sum24 !== 24'h010000) begin n_fail++; $display("FAIL w24_sum got %h want 010000", sum24); end
        n_checks++; if (co24 !== 1'b0) begin n_fail++; $display("FAIL w24_co got %b want 0", co24); end
        n_checks++; if (ov24 !== 1'b0) begin n_fail++; $display("FAIL w24_ov got %b want 0", ov24); end
        idle(2);
    endtask

    initial begin
        RESET = 1'b1;
        A = '0; B = '0; CI = 1'b0; SUB = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        a24 = '0; b24 = '0; ci24 = 1'b0; sub24 = 1'b0; in_valid24 = 1'b0; out_ready24 = 1'b1;
        test_reset();
        test_ripple();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_reset_midflight_w24();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
